stack_arbiter: RTL and testbench

Shares one 16-entry LIFO stack between two independent requesters (A, B). Arbitrates them round-robin, one push or pop per transaction. Sequences the stack's push/pop strobes and screens out illegal operations (push when full, pop when empty) before they reach the stack. Returns popped data and a completion handshake to the winning requester. Sits directly in front of the stack; it is the stack's only driver.

---
 rtl/stack_arb_pkg.sv | 26 ++
 rtl/stack_arbiter_rr_arb2.sv | 33 +++
 rtl/stack_arbiter.sv | 147 ++++++++++++++
 tb/tb_stack_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg
// Shared types and constants for the two-requester stack arbiter.
//   state_t    : transaction sequencer states
//   OP_*       : request opcode encoding (push / pop)
//   REQ_*      : requester id encoding (A / B)
//   is_illegal : screens a push into a full stack or a pop from an empty one
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic is_illegal(input logic op, input logic empty, input logic full);
    return (op == OP_POP) ? empty : full;
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin picker. The pointer (last winner) is
// held by the caller; this block only decides who wins this cycle.
// Ports:
//   req[1:0]    in  request vector, bit 0 = A, bit 1 = B
//   last_winner in  id of the previously granted requester
//   gnt[1:0]    out one-hot grant (all zero when nobody requests)
//   winner      out id of the granted requester (REQ_A when nobody requests)
module rr_arb2
  import stack_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt,
  output logic       winner
);

  // On a tie the previous winner yields; a lone requester always wins.
  always_comb begin
    winner = REQ_A;
    if (req == 2'b11) begin
      winner = ~last_winner;
    end else if (req[1]) begin
      winner = REQ_B;
    end

    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = (winner == REQ_B) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter
// Shares one 16-entry LIFO between requesters A and B. One push or pop is in
// flight at a time; illegal operations (push when full, pop when empty) are
// rejected without touching the stack.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_x, op_x, wdata_x    requester x: request, opcode (0 push / 1 pop), push data
//   gnt_x, err_x, rvalid_x  requester x: completion pulse, rejected, pop data valid
//   rdata                   last successfully popped value
//   stk_push, stk_pop       stack strobes (never both high)
//   stk_din                 stack write data
//   stk_dout                stack read data, valid one edge after stk_pop
//   stk_empty, stk_full     stack flags
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          op_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          op_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          err_a,
  output logic          rvalid_a,
  output logic          gnt_b,
  output logic          err_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  input  logic          stk_empty,
  input  logic          stk_full
);

  state_t        state_q, state_d;
  logic          winner_q, winner_d;
  logic          op_q, op_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [1:0]    arb_gnt;
  logic          arb_winner;

  rr_arb2 u_rr_arb2 (
    .req         ({req_b, req_a}),
    .last_winner (last_q),
    .gnt         (arb_gnt),
    .winner      (arb_winner)
  );

  // Transaction sequencer. The RR pointer moves only on the transition into
  // DONE, so a rejected request still counts as having been served.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    op_d     = op_q;
    err_d    = err_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          winner_d = arb_winner;
          op_d     = (arb_winner == REQ_B) ? op_b : op_a;
          wdata_d  = (arb_winner == REQ_B) ? wdata_b : wdata_a;
          // Flags are stable in IDLE because nothing else drives the stack.
          err_d    = is_illegal(op_d, stk_empty, stk_full);
          if (err_d) begin
            state_d = DONE;
            last_d  = arb_winner;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q == OP_POP) begin
          state_d = CAPTURE;
        end else begin
          state_d = DONE;
          last_d  = winner_q;
        end
      end
      CAPTURE: begin
        rdata_d = stk_dout;
        state_d = DONE;
        last_d  = winner_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= REQ_A;
      op_q     <= OP_PUSH;
      err_q    <= 1'b0;
      last_q   <= REQ_B;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      op_q     <= op_d;
      err_q    <= err_d;
      last_q   <= last_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decode only registered state, so request inputs never reach them
  // combinationally and reset drops the strobes immediately.
  logic in_done;
  assign in_done  = (state_q == DONE);

  assign gnt_a    = in_done && (winner_q == REQ_A);
  assign gnt_b    = in_done && (winner_q == REQ_B);
  assign err_a    = gnt_a && err_q;
  assign err_b    = gnt_b && err_q;
  assign rvalid_a = gnt_a && !err_q && (op_q == OP_POP);
  assign rvalid_b = gnt_b && !err_q && (op_q == OP_POP);

  assign stk_push = (state_q == ISSUE) && (op_q == OP_PUSH);
  assign stk_pop  = (state_q == ISSUE) && (op_q == OP_POP);
  assign stk_din  = wdata_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
// Directed bench for stack_arbiter with a behavioural 16-entry LIFO behind it.
// Each table record describes one transaction and its hand-computed outcome.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, op_a, req_b, op_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, err_a, rvalid_a, gnt_b, err_b, rvalid_b;
  logic [DW-1:0] rdata;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic          stk_empty, stk_full;

  int tests_run = 0;
  int tests_failed = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  stack_arbiter #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .op_a      (op_a),
    .wdata_a   (wdata_a),
    .req_b     (req_b),
    .op_b      (op_b),
    .wdata_b   (wdata_b),
    .gnt_a     (gnt_a),
    .err_a     (err_a),
    .rvalid_a  (rvalid_a),
    .gnt_b     (gnt_b),
    .err_b     (err_b),
    .rvalid_b  (rvalid_b),
    .rdata     (rdata),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_empty (stk_empty),
    .stk_full  (stk_full)
  );

  // Behavioural LIFO: registered read data, ignores strobes that would
  // overflow or underflow, and shares reset with the arbiter via !rst_n.
  logic [DW-1:0] stk_mem [DEPTH];
  logic [4:0]    stk_cnt;
  logic          stk_rst;
  assign stk_rst   = !rst_n;
  assign stk_empty = (stk_cnt == 5'd0);
  assign stk_full  = (stk_cnt == 5'd16);

  always @(posedge clk or posedge stk_rst) begin
    if (stk_rst) begin
      stk_cnt  <= 5'd0;
      stk_dout <= '0;
    end else if (stk_push && !stk_full) begin
      stk_mem[stk_cnt[3:0]] <= stk_din;
      stk_cnt <= stk_cnt + 5'd1;
    end else if (stk_pop && !stk_empty) begin
      stk_dout <= stk_mem[stk_cnt[3:0] - 4'd1];
      stk_cnt  <= stk_cnt - 5'd1;
    end
  end

  typedef struct {
    string         name;
    logic          ra;
    logic          rb;
    logic          oa;
    logic          ob;
    logic [DW-1:0] wa;
    logic [DW-1:0] wb;
    logic          win;
    int            lat;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic ra, input logic rb,
                              input logic oa, input logic ob,
                              input logic [DW-1:0] wa, input logic [DW-1:0] wb,
                              input logic win, input int lat, input logic err,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.name = n; v.ra = ra; v.rb = rb; v.oa = oa; v.ob = ob;
    v.wa = wa; v.wb = wb; v.win = win; v.lat = lat;
    v.exp_err = err; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting in an IDLE cycle and ends in the next IDLE
  // cycle. Outputs are packed as {gnt_a,gnt_b,err_a,err_b,rvalid_a,rvalid_b,push,pop}.
  task automatic applyStimulus(input vec_t v);
    logic          wop;
    logic [DW-1:0] wdin;
    logic          e_push, e_pop, e_rv, at_gnt;
    logic [7:0]    exp_bus;
    req_a = v.ra; op_a = v.oa; wdata_a = v.wa;
    req_b = v.rb; op_b = v.ob; wdata_b = v.wb;
    wop    = (v.win == REQ_B) ? v.ob : v.oa;
    wdin   = (v.win == REQ_B) ? v.wb : v.wa;
    e_push = !v.exp_err && (wop == OP_PUSH);
    e_pop  = !v.exp_err && (wop == OP_POP);
    e_rv   = e_pop;
    checkOutput({v.name, " c0 outputs"},
                {gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, stk_push, stk_pop}, 8'h00);
    for (int cyc = 1; cyc <= v.lat; cyc++) begin
      stepCycle();
      at_gnt  = (cyc == v.lat);
      exp_bus = {at_gnt && v.win == REQ_A, at_gnt && v.win == REQ_B,
                 at_gnt && v.win == REQ_A && v.exp_err,
                 at_gnt && v.win == REQ_B && v.exp_err,
                 at_gnt && v.win == REQ_A && e_rv,
                 at_gnt && v.win == REQ_B && e_rv,
                 cyc == 1 && e_push, cyc == 1 && e_pop};
      checkOutput($sformatf("%s c%0d outputs", v.name, cyc),
                  {gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, stk_push, stk_pop},
                  exp_bus);
      if (cyc == 1 && e_push) begin
        checkOutput({v.name, " stk_din"}, stk_din, wdin);
      end
    end
    checkOutput({v.name, " rdata"}, rdata, v.exp_rdata);
    stepCycle();
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence: reset, table of transactions, then mid-transaction reset.
  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; op_a = OP_PUSH; wdata_a = '0;
    req_b = 1'b0; op_b = OP_PUSH; wdata_b = '0;
    #12;
    checkOutput("reset outputs",
                {gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, stk_push, stk_pop}, 8'h00);
    checkOutput("reset stk_din", stk_din, 8'h00);
    checkOutput("reset rdata", rdata, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vecs.push_back(mk("a_push_5a", 1, 0, OP_PUSH, OP_PUSH, 8'h5A, 8'h00, REQ_A, 2, 0, 8'h00));
    vecs.push_back(mk("a_pop_5a", 1, 0, OP_POP, OP_PUSH, 8'h00, 8'h00, REQ_A, 3, 0, 8'h5A));
    vecs.push_back(mk("b_pop_empty", 0, 1, OP_PUSH, OP_POP, 8'h00, 8'h00, REQ_B, 1, 1, 8'h5A));
    vecs.push_back(mk("tie1", 1, 1, OP_PUSH, OP_PUSH, 8'h11, 8'h22, REQ_A, 2, 0, 8'h5A));
    vecs.push_back(mk("tie2", 1, 1, OP_PUSH, OP_PUSH, 8'h11, 8'h22, REQ_B, 2, 0, 8'h5A));
    vecs.push_back(mk("tie3", 1, 1, OP_PUSH, OP_PUSH, 8'h11, 8'h22, REQ_A, 2, 0, 8'h5A));
    vecs.push_back(mk("tie4", 1, 1, OP_PUSH, OP_PUSH, 8'h11, 8'h22, REQ_B, 2, 0, 8'h5A));
    for (int i = 0; i < 12; i++) begin
      vecs.push_back(mk($sformatf("fill%0d", i), 1, 0, OP_PUSH, OP_PUSH,
                        8'(8'h80 + i), 8'h00, REQ_A, 2, 0, 8'h5A));
    end
    vecs.push_back(mk("b_push_full", 0, 1, OP_PUSH, OP_PUSH, 8'h00, 8'hEE, REQ_B, 1, 1, 8'h5A));
    vecs.push_back(mk("b_pop_16th", 0, 1, OP_PUSH, OP_POP, 8'h00, 8'h00, REQ_B, 3, 0, 8'h8B));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    stepCycle();

    // Reset lands in the ISSUE cycle of a pop from A.
    req_a = 1'b1; op_a = OP_POP;
    stepCycle();
    checkOutput("pre-reset stk_pop", stk_pop, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset outputs",
                {gnt_a, gnt_b, err_a, err_b, rvalid_a, rvalid_b, stk_push, stk_pop}, 8'h00);
    checkOutput("mid-reset rdata", rdata, 8'h00);
    req_a = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      stepCycle();
      checkOutput($sformatf("post-reset quiet c%0d", cyc),
                  {gnt_a, gnt_b, stk_push, stk_pop}, 4'h0);
    end

    applyStimulus(mk("rst_tie_a", 1, 1, OP_PUSH, OP_PUSH, 8'h33, 8'h44, REQ_A, 2, 0, 8'h00));
    applyStimulus(mk("rst_tie_b", 1, 1, OP_PUSH, OP_PUSH, 8'h33, 8'h44, REQ_B, 2, 0, 8'h00));
    applyStimulus(mk("rst_a_pop", 1, 0, OP_POP, OP_PUSH, 8'h00, 8'h00, REQ_A, 3, 0, 8'h44));
    req_a = 1'b0;
    req_b = 1'b0;
    stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
